pipeline_hazard_ctrl: RTL and testbench

- Central sequencer for the 5-stage pipeline latches (fetch/decode, decode/execute, execute/mem, mem/writeback) and the PC register.
- Every cycle it issues one pipe_state_t command per latch (PIPE_ENABLE, PIPE_STALL or PIPE_NOP) plus a PC enable.
- It resolves I-cache and D-cache waits, load-use hazards, taken branches/jumps and halt drain.
- A small FSM tracks the multi-cycle conditions: D-cache wait and halt.

---
 rtl/pipeline_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Purpose:
//   Central sequencer for the four pipeline latches (fetch/decode,
//   decode/execute, execute/mem, mem/writeback) and the PC register of the
//   5-stage CPU. Every cycle it issues one pipe_state_t command per latch
//   (PIPE_ENABLE, PIPE_STALL, PIPE_NOP) and a PC enable, resolving I-cache
//   and D-cache waits, load-use hazards, taken branches/jumps and halt drain.
//   A small FSM (RUN, DWAIT, HALT_DRAIN, HALTED) tracks the multi-cycle
//   conditions. Latch commands and pc_en are combinational from the current
//   inputs and state; halt is registered.
//
// Optional feature (macro PIPE_HAZARD_PERF_EN):
//   Adds three saturating 32-bit performance counters: stall_cnt (load-use or
//   I-miss bubbles), flush_cnt (redirect flushes), dwait_cnt (D-cache wait
//   cycles). They clear on reset and freeze once the CPU is halted.
//
// Ports:
//   CLK          in   system clock, rising edge
//   nRST         in   synchronous active-low reset
//   ihit         in   instruction fetch completes this cycle
//   dhit         in   data access completes this cycle
//   dREN_mem     in   load in MEM stage
//   dWEN_mem     in   store in MEM stage
//   halt_mem     in   halt instruction in MEM stage
//   redirect_ex  in   taken branch/jump resolved in EX
//   dREN_ex      in   load in EX stage
//   wsel_ex      in   destination register of the EX instruction
//   rs_dec       in   rs source register of the DEC instruction
//   rt_dec       in   rt source register of the DEC instruction
//   use_rs_dec   in   DEC instruction reads rs
//   use_rt_dec   in   DEC instruction reads rt
//   fd_state     out  fetch/decode latch command
//   de_state     out  decode/execute latch command
//   em_state     out  execute/mem latch command
//   mw_state     out  mem/writeback latch command
//   pc_en        out  PC loads its next value
//   halt         out  CPU halted (registered)
//   stall_cnt    out  [PIPE_HAZARD_PERF_EN only] stall cycle counter
//   flush_cnt    out  [PIPE_HAZARD_PERF_EN only] flush cycle counter
//   dwait_cnt    out  [PIPE_HAZARD_PERF_EN only] D-wait cycle counter
// -----------------------------------------------------------------------------

package pipeline_hazard_ctrl_pkg;
  typedef enum logic [1:0] {
    PIPE_ENABLE = 2'd0,
    PIPE_STALL  = 2'd1,
    PIPE_NOP    = 2'd2
  } pipe_state_t;
endpackage

module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              dREN_mem,
  input  logic              dWEN_mem,
  input  logic              halt_mem,
  input  logic              redirect_ex,
  input  logic              dREN_ex,
  input  logic [REG_W-1:0]  wsel_ex,
  input  logic [REG_W-1:0]  rs_dec,
  input  logic [REG_W-1:0]  rt_dec,
  input  logic              use_rs_dec,
  input  logic              use_rt_dec,
  output pipe_state_t       fd_state,
  output pipe_state_t       de_state,
  output pipe_state_t       em_state,
  output pipe_state_t       mw_state,
  output logic              pc_en,
  output logic              halt
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
  output logic [31:0]       dwait_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    DWAIT      = 2'd1,
    HALT_DRAIN = 2'd2,
    HALTED     = 2'd3
  } fsm_t;

  fsm_t state_reg, state_next;
  logic halt_reg;

  logic dmem;
  logic dmiss;
  logic lu;

  assign dmem  = dREN_mem | dWEN_mem;
  // A data access that completes in the same cycle is not a stall.
  assign dmiss = dmem & ~dhit;

  // Load-use: a load in EX feeding a register the DEC instruction really
  // reads. Register 0 is hardwired, so a load targeting it never hazards.
  assign lu = dREN_ex & (wsel_ex != '0) &
              ((use_rs_dec & (wsel_ex == rs_dec)) |
               (use_rt_dec & (wsel_ex == rt_dec)));

  // ---------------------------------------------------------------------------
  // Command decode and next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    fd_state   = PIPE_NOP;
    de_state   = PIPE_NOP;
    em_state   = PIPE_NOP;
    mw_state   = PIPE_NOP;
    pc_en      = 1'b0;

    if (!nRST) begin
      // Reset forces bubbles everywhere regardless of the other inputs.
      state_next = RUN;
    end else begin
      case (state_reg)
        RUN, DWAIT: begin
          // DWAIT decodes exactly like RUN: the dhit cycle falls through to
          // the lower-priority rules, so a redirect held in EX during the
          // wait is serviced here unless a halt claims the cycle.
          if (dmiss) begin
            fd_state   = PIPE_STALL;
            de_state   = PIPE_STALL;
            em_state   = PIPE_STALL;
            mw_state   = PIPE_NOP;
            state_next = DWAIT;
          end else if (halt_mem) begin
            mw_state   = PIPE_ENABLE;
            state_next = HALT_DRAIN;
          end else if (redirect_ex) begin
            // Target is valid in the PC mux even if the fetch has not hit.
            em_state   = PIPE_ENABLE;
            mw_state   = PIPE_ENABLE;
            pc_en      = 1'b1;
            state_next = RUN;
          end else if (lu) begin
            fd_state   = PIPE_STALL;
            em_state   = PIPE_ENABLE;
            mw_state   = PIPE_ENABLE;
            state_next = RUN;
          end else if (!ihit) begin
            de_state   = PIPE_ENABLE;
            em_state   = PIPE_ENABLE;
            mw_state   = PIPE_ENABLE;
            state_next = RUN;
          end else begin
            fd_state   = PIPE_ENABLE;
            de_state   = PIPE_ENABLE;
            em_state   = PIPE_ENABLE;
            mw_state   = PIPE_ENABLE;
            pc_en      = 1'b1;
            state_next = RUN;
          end
        end
        HALT_DRAIN: begin
          fd_state   = PIPE_STALL;
          de_state   = PIPE_STALL;
          em_state   = PIPE_STALL;
          mw_state   = PIPE_STALL;
          state_next = HALTED;
        end
        HALTED: begin
          fd_state   = PIPE_STALL;
          de_state   = PIPE_STALL;
          em_state   = PIPE_STALL;
          mw_state   = PIPE_STALL;
          state_next = HALTED;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg <= RUN;
      halt_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      // halt rises on the edge that leaves HALT_DRAIN and then sticks.
      if (state_reg == HALT_DRAIN) begin
        halt_reg <= 1'b1;
      end
    end
  end

  assign halt = halt_reg;

`ifdef PIPE_HAZARD_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  logic running;
  logic dwait_hit;
  logic flush_hit;
  logic stall_hit;

  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;
  logic [31:0] dwait_cnt_reg;

  // Only RUN/DWAIT evaluate the priority rules; drain and halted freeze.
  assign running   = nRST & ((state_reg == RUN) | (state_reg == DWAIT));
  assign dwait_hit = running & dmiss;
  assign flush_hit = running & ~dmiss & ~halt_mem & redirect_ex;
  assign stall_hit = running & ~dmiss & ~halt_mem & ~redirect_ex & (lu | ~ihit);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
      dwait_cnt_reg <= '0;
    end else begin
      if (stall_hit && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (flush_hit && (flush_cnt_reg != 32'hFFFF_FFFF)) begin
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
      end
      if (dwait_hit && (dwait_cnt_reg != 32'hFFFF_FFFF)) begin
        dwait_cnt_reg <= dwait_cnt_reg + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
  assign dwait_cnt = dwait_cnt_reg;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Self-checking bench for pipeline_hazard_ctrl: directed scenario tasks with
// constant expectations, then a randomized run checked against a behavioural
// model of the hazard rules. Build with PIPE_HAZARD_PERF_EN defined to also
// exercise the performance counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  localparam int REG_W = 5;

  logic             CLK;
  logic             nRST;
  logic             ihit, dhit, dREN_mem, dWEN_mem, halt_mem, redirect_ex, dREN_ex;
  logic [REG_W-1:0] wsel_ex, rs_dec, rt_dec;
  logic             use_rs_dec, use_rt_dec;
  pipe_state_t      fd_state, de_state, em_state, mw_state;
  logic             pc_en, halt;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0]      stall_cnt, flush_cnt, dwait_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model state: where the halt sequence stands.
  logic m_drain  = 1'b0;
  logic m_halted = 1'b0;
  logic m_halt   = 1'b0;

  pipeline_hazard_ctrl #(.REG_W(REG_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .halt_mem(halt_mem),
    .redirect_ex(redirect_ex), .dREN_ex(dREN_ex), .wsel_ex(wsel_ex),
    .rs_dec(rs_dec), .rt_dec(rt_dec), .use_rs_dec(use_rs_dec), .use_rt_dec(use_rt_dec),
    .fd_state(fd_state), .de_state(de_state), .em_state(em_state), .mw_state(mw_state),
    .pc_en(pc_en), .halt(halt)
`ifdef PIPE_HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .dwait_cnt(dwait_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [9:0] obs;
  assign obs = {fd_state, de_state, em_state, mw_state, pc_en, halt};

  function automatic logic [9:0] pk(pipe_state_t f, pipe_state_t d, pipe_state_t e,
                                    pipe_state_t m, logic pc, logic h);
    return {f, d, e, m, pc, h};
  endfunction

  // Expected outputs from the hazard rules, given the current inputs.
  function automatic logic [9:0] model_exp();
    logic hazard;
    if (!nRST) return pk(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_NOP, 1'b0, m_halt);
    if (m_drain || m_halted) return pk(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL, 1'b0, m_halt);
    hazard = dREN_ex && (wsel_ex != 0) &&
             ((use_rs_dec && rs_dec == wsel_ex) || (use_rt_dec && rt_dec == wsel_ex));
    if ((dREN_mem || dWEN_mem) && !dhit) return pk(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_NOP, 1'b0, m_halt);
    if (halt_mem)    return pk(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_ENABLE, 1'b0, m_halt);
    if (redirect_ex) return pk(PIPE_NOP, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, 1'b1, m_halt);
    if (hazard)      return pk(PIPE_STALL, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, 1'b0, m_halt);
    if (!ihit)       return pk(PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b0, m_halt);
    return pk(PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b1, m_halt);
  endfunction

  // Advance the model on a clock edge using the inputs held at that edge.
  task automatic model_advance();
    if (!nRST) begin
      m_drain = 1'b0; m_halted = 1'b0; m_halt = 1'b0;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (m_drain) begin
      m_drain = 1'b0; m_halted = 1'b1; m_halt = 1'b1;
    end else if (!((dREN_mem || dWEN_mem) && !dhit) && halt_mem) begin
      m_drain = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_advance();
    #1;
  endtask

  task automatic idle();
    nRST = 1'b1; ihit = 1'b1; dhit = 1'b0; dREN_mem = 1'b0; dWEN_mem = 1'b0;
    halt_mem = 1'b0; redirect_ex = 1'b0; dREN_ex = 1'b0;
    wsel_ex = '0; rs_dec = '0; rt_dec = '0; use_rs_dec = 1'b0; use_rt_dec = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    nRST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      compared++;
      if (obs !== pk(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_NOP, 1'b0, 1'b0)) begin
        mismatched++;
        $display("FAIL reset_hold[%0d]: got %b want %b", i, obs,
                 pk(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_NOP, 1'b0, 1'b0));
      end
      tick();
    end
    nRST = 1'b1;
    @(negedge CLK);
    compared++;
    if (obs !== pk(PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b1, 1'b0)) begin
      mismatched++;
      $display("FAIL reset_release: got %b want %b", obs,
               pk(PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b1, 1'b0));
    end
    tick();
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    logic [9:0] want_lu, want_run;
    want_lu  = pk(PIPE_STALL, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, 1'b0, 1'b0);
    want_run = pk(PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b1, 1'b0);
    idle();
    dREN_ex = 1'b1; wsel_ex = 5'd5; rs_dec = 5'd5; use_rs_dec = 1'b1;
    @(negedge CLK);
    compared++;
    if (obs !== want_lu) begin mismatched++; $display("FAIL lu_rs: got %b want %b", obs, want_lu); end
    tick();
    wsel_ex = 5'd0; rs_dec = 5'd0;
    @(negedge CLK);
    compared++;
    if (obs !== want_run) begin mismatched++; $display("FAIL lu_r0: got %b want %b", obs, want_run); end
    tick();
    wsel_ex = 5'd7; rs_dec = 5'd7; use_rs_dec = 1'b0; rt_dec = 5'd7; use_rt_dec = 1'b1;
    @(negedge CLK);
    compared++;
    if (obs !== want_lu) begin mismatched++; $display("FAIL lu_rt: got %b want %b", obs, want_lu); end
    tick();
    use_rt_dec = 1'b0;
    @(negedge CLK);
    compared++;
    if (obs !== want_run) begin mismatched++; $display("FAIL lu_unused: got %b want %b", obs, want_run); end
    tick();
    $display("test_load_use done");
  endtask

  task automatic test_dwait();
    logic [9:0] want_w, want_run;
    want_w   = pk(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_NOP, 1'b0, 1'b0);
    want_run = pk(PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b1, 1'b0);
    idle();
    dREN_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      compared++;
      if (obs !== want_w) begin mismatched++; $display("FAIL dwait[%0d]: got %b want %b", i, obs, want_w); end
      tick();
    end
    dhit = 1'b1;
    @(negedge CLK);
    compared++;
    if (obs !== want_run) begin mismatched++; $display("FAIL dwait_hit: got %b want %b", obs, want_run); end
    tick();
    // Reset in the middle of a wait leaves nothing pending.
    dhit = 1'b0; tick();
    nRST = 1'b0; tick();
    idle();
    @(negedge CLK);
    compared++;
    if (obs !== want_run) begin mismatched++; $display("FAIL dwait_reset: got %b want %b", obs, want_run); end
    tick();
    $display("test_dwait done");
  endtask

  task automatic test_redirect();
    logic [9:0] want_rd, want_w;
    want_rd = pk(PIPE_NOP, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, 1'b1, 1'b0);
    want_w  = pk(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_NOP, 1'b0, 1'b0);
    idle();
    redirect_ex = 1'b1; ihit = 1'b0;
    @(negedge CLK);
    compared++;
    if (obs !== want_rd) begin mismatched++; $display("FAIL redirect_imiss: got %b want %b", obs, want_rd); end
    tick();
    dWEN_mem = 1'b1;
    @(negedge CLK);
    compared++;
    if (obs !== want_w) begin mismatched++; $display("FAIL redirect_dwait: got %b want %b", obs, want_w); end
    tick();
    dhit = 1'b1;
    @(negedge CLK);
    compared++;
    if (obs !== want_rd) begin mismatched++; $display("FAIL redirect_on_dhit: got %b want %b", obs, want_rd); end
    tick();
    $display("test_redirect done");
  endtask

  task automatic test_halt();
    logic [9:0] want_st;
    idle();
    halt_mem = 1'b1;
    @(negedge CLK);
    compared++;
    if (obs !== pk(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_ENABLE, 1'b0, 1'b0)) begin
      mismatched++;
      $display("FAIL halt_mem: got %b want %b", obs, pk(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_ENABLE, 1'b0, 1'b0));
    end
    tick();
    halt_mem = 1'b0;
    @(negedge CLK);
    compared++;
    want_st = pk(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL, 1'b0, 1'b0);
    if (obs !== want_st) begin mismatched++; $display("FAIL halt_drain: got %b want %b", obs, want_st); end
    tick();
    want_st = pk(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      ihit = 1'($urandom); dhit = 1'($urandom); redirect_ex = 1'($urandom);
      dREN_mem = 1'($urandom); halt_mem = 1'($urandom); dREN_ex = 1'($urandom);
      @(negedge CLK);
      compared++;
      if (obs !== want_st) begin mismatched++; $display("FAIL halted[%0d]: got %b want %b", i, obs, want_st); end
      tick();
    end
    idle();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    @(negedge CLK);
    compared++;
    if (obs !== pk(PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b1, 1'b0)) begin
      mismatched++;
      $display("FAIL halt_reset: got %b want %b", obs, pk(PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b1, 1'b0));
    end
    tick();
    $display("test_halt done");
  endtask

  task automatic test_random();
    logic [9:0] want;
    idle();
    for (int i = 0; i < 600; i++) begin
      nRST        = ($urandom_range(0, 99) >= 2);
      ihit        = ($urandom_range(0, 99) < 75);
      dhit        = ($urandom_range(0, 99) < 50);
      dREN_mem    = ($urandom_range(0, 99) < 20);
      dWEN_mem    = ($urandom_range(0, 99) < 15);
      halt_mem    = ($urandom_range(0, 99) < 3);
      redirect_ex = ($urandom_range(0, 99) < 20);
      dREN_ex     = ($urandom_range(0, 99) < 50);
      wsel_ex     = REG_W'($urandom_range(0, 3));
      rs_dec      = REG_W'($urandom_range(0, 3));
      rt_dec      = REG_W'($urandom_range(0, 3));
      use_rs_dec  = 1'($urandom);
      use_rt_dec  = 1'($urandom);
      @(negedge CLK);
      want = model_exp();
      compared++;
      $display("rand %0d rst_n=%b ih=%b dh=%b dm=%b%b hm=%b rd=%b lx=%b w=%0d rs=%0d rt=%0d ur=%b%b out=%b",
               i, nRST, ihit, dhit, dREN_mem, dWEN_mem, halt_mem, redirect_ex, dREN_ex,
               wsel_ex, rs_dec, rt_dec, use_rs_dec, use_rt_dec, obs);
      if (obs !== want) begin mismatched++; $display("FAIL random[%0d]: got %b want %b", i, obs, want); end
      tick();
    end
    $display("test_random done");
  endtask

`ifdef PIPE_HAZARD_PERF_EN
  task automatic test_perf();
    idle();
    nRST = 1'b0; tick();
    idle();
    dREN_ex = 1'b1; wsel_ex = 5'd3; rs_dec = 5'd3; use_rs_dec = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    idle();
    redirect_ex = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    idle();
    dREN_mem = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    dhit = 1'b1; tick();
    idle();
    @(negedge CLK);
    compared++;
    if (stall_cnt !== 32'd4) begin mismatched++; $display("FAIL stall_cnt: got %0d want 4", stall_cnt); end
    compared++;
    if (flush_cnt !== 32'd2) begin mismatched++; $display("FAIL flush_cnt: got %0d want 2", flush_cnt); end
    compared++;
    if (dwait_cnt !== 32'd3) begin mismatched++; $display("FAIL dwait_cnt: got %0d want 3", dwait_cnt); end
    tick();
    $display("test_perf done");
  endtask
`endif

  initial begin
    idle();
    nRST = 1'b0;
    test_reset();
    test_load_use();
    test_dwait();
    test_redirect();
    test_halt();
    test_random();
`ifdef PIPE_HAZARD_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
